// File: rtl/ram_arbiter_pkg.sv
// Shared types for the fetch/data RAM arbiter: RAM handshake states, access widths,
// arbiter FSM states and the alignment rule.
package ram_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RAM_FREE  = 2'b00,
        RAM_ADDR  = 2'b01,
        RAM_DATA  = 2'b10,
        RAM_ERROR = 2'b11
    } ram_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FAULT
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 64;

    // Registered outputs of the arbiter, kept together so the next-state logic
    // can start from "hold everything" and override only what changes.
    typedef struct packed {
        logic       ren;
        logic       wen;
        word_t      addr;
        word_t      store;
        mem_width_t width;
        logic       i_rdy;
        logic       i_err;
        word_t      i_rdata;
        logic       d_rdy;
        logic       d_err;
        word_t      d_rdata;
    } arb_out_t;

    // Width 2'b11 is not a legal access and falls to the default arm.
    function automatic logic addr_ok(input logic [1:0] off, input mem_width_t w);
        case (w)
            BYTE:    return 1'b1;
            HALF:    return ~off[0];
            WORD:    return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Core-side fetch/data ports plus the RAM responder lines. The arbiter takes the
// slave view; the core/RAM environment takes the master view.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic       i_req;
    word_t      i_addr;
    logic       i_rdy;
    word_t      i_rdata;
    logic       i_err;

    logic       d_req;
    logic       d_wen;
    word_t      d_addr;
    mem_width_t d_width;
    logic       d_unsigned;
    word_t      d_wdata;
    logic       d_rdy;
    word_t      d_rdata;
    logic       d_err;

    logic       ram_ren;
    logic       ram_wen;
    word_t      ram_addr;
    word_t      ram_store;
    mem_width_t ram_width;
    ram_state_t ram_state;
    word_t      ram_load;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_width, d_unsigned, d_wdata,
               ram_state, ram_load,
        output i_rdy, i_rdata, i_err, d_rdy, d_rdata, d_err,
               ram_ren, ram_wen, ram_addr, ram_store, ram_width
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_width, d_unsigned, d_wdata,
               ram_state, ram_load,
        input  i_rdy, i_rdata, i_err, d_rdy, d_rdata, d_err,
               ram_ren, ram_wen, ram_addr, ram_store, ram_width
    );

endinterface

// File: rtl/ram_arbiter_load_align.sv
// Sub-word load extraction: shift the RAM word down to the addressed byte lane,
// then sign- or zero-extend to 32 bits according to the access width.
module ram_arbiter_load_align
    import ram_arbiter_pkg::*;
(
    input  word_t      raw,
    input  logic [1:0] off,
    input  mem_width_t width,
    input  logic       uns,
    output word_t      data
);

    word_t sh;

    always_comb begin
        sh = raw >> {off, 3'b000};
        case (width)
            BYTE:    data = {{24{~uns & sh[7]}}, sh[7:0]};
            HALF:    data = {{16{~uns & sh[15]}}, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of the fetch and data ports onto one RAM responder, with
// alignment checking, sub-word load extraction and a per-transaction timeout.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic          ram_clk,
    input logic          nrst,
    ram_arbiter_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state, state_n;
    arb_out_t      o, o_n;
    logic          cur_d, cur_d_n;
    logic          last_d, last_d_n;
    logic [CW-1:0] cnt, cnt_n;

    logic  fi, fd, pick_d, legal;
    logic  fin, fin_err;
    word_t fin_data, aligned;

    ram_arbiter_load_align u_align (
        .raw   (bus.ram_load),
        .off   (o.addr[1:0]),
        .width (o.width),
        .uns   (bus.d_unsigned),
        .data  (aligned)
    );

    always_ff @(posedge ram_clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            o      <= '0;
            cur_d  <= 1'b0;
            last_d <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            o      <= o_n;
            cur_d  <= cur_d_n;
            last_d <= last_d_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        o_n      = o;
        o_n.i_rdy = 1'b0;
        o_n.i_err = 1'b0;
        o_n.d_rdy = 1'b0;
        o_n.d_err = 1'b0;
        cur_d_n  = cur_d;
        last_d_n = last_d;
        cnt_n    = cnt;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;

        // A port whose rdy is showing this cycle is still holding its old request.
        fi     = bus.i_req & ~o.i_rdy;
        fd     = bus.d_req & ~o.d_rdy;
        pick_d = fd & (~fi | ~last_d);
        legal  = pick_d ? addr_ok(bus.d_addr[1:0], bus.d_width) : (bus.i_addr[1:0] == 2'b00);

        case (state)
            IDLE: begin
                if (fi | fd) begin
                    cur_d_n  = pick_d;
                    last_d_n = pick_d;
                    cnt_n    = '0;
                    if (legal) begin
                        state_n   = BUSY;
                        o_n.ren   = ~(pick_d & bus.d_wen);
                        o_n.wen   = pick_d & bus.d_wen;
                        o_n.addr  = pick_d ? bus.d_addr : bus.i_addr;
                        o_n.width = pick_d ? bus.d_width : WORD;
                        o_n.store = pick_d ? bus.d_wdata : '0;
                    end else begin
                        state_n = FAULT;
                    end
                end
            end
            BUSY: begin
                if (bus.ram_state == RAM_DATA) begin
                    fin      = 1'b1;
                    fin_data = !cur_d ? bus.ram_load : (o.wen ? '0 : aligned);
                end else if (bus.ram_state == RAM_ERROR) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            FAULT: begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Dropping the enables here gives the responder an idle cycle to clear.
        if (fin) begin
            state_n = IDLE;
            o_n.ren = 1'b0;
            o_n.wen = 1'b0;
            if (cur_d) begin
                o_n.d_rdy   = 1'b1;
                o_n.d_err   = fin_err;
                o_n.d_rdata = fin_data;
            end else begin
                o_n.i_rdy   = 1'b1;
                o_n.i_err   = fin_err;
                o_n.i_rdata = fin_data;
            end
        end
    end

    assign bus.ram_ren   = o.ren;
    assign bus.ram_wen   = o.wen;
    assign bus.ram_addr  = o.addr;
    assign bus.ram_store = o.store;
    assign bus.ram_width = o.width;
    assign bus.i_rdy     = o.i_rdy;
    assign bus.i_err     = o.i_err;
    assign bus.i_rdata   = o.i_rdata;
    assign bus.d_rdy     = o.d_rdy;
    assign bus.d_err     = o.d_err;
    assign bus.d_rdata   = o.d_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte-array RAM responder with normal/error/stuck modes,
// directed vector table, reset corner cases and randomized traffic vs a word-level model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int TO = 8;

    logic ram_clk = 1'b0;
    logic nrst    = 1'b0;
    always #5 ram_clk = ~ram_clk;

    ram_arbiter_if bus ();

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .ram_clk (ram_clk),
        .nrst    (nrst),
        .bus     (bus.slave)
    );

    // ---------------- responder: 0 = zero latency, 1 = error, 2 = never answers
    logic [7:0] ram_mem [0:4095];
    ram_state_t rs;
    int         resp_mode = 0;
    logic [11:0] ra;

    assign ra            = {bus.ram_addr[11:2], 2'b00};
    assign bus.ram_state = rs;
    assign bus.ram_load  = (rs == RAM_DATA) ?
        {ram_mem[ra + 12'd3], ram_mem[ra + 12'd2], ram_mem[ra + 12'd1], ram_mem[ra]} : 32'h0;

    always @(posedge ram_clk or negedge nrst) begin
        if (!nrst) rs <= RAM_FREE;
        else if (resp_mode == 2) rs <= (bus.ram_ren | bus.ram_wen) ? RAM_ADDR : RAM_FREE;
        else if (rs == RAM_FREE && (bus.ram_ren | bus.ram_wen)) begin
            rs <= (resp_mode == 1) ? RAM_ERROR : RAM_DATA;
            if (bus.ram_wen && resp_mode == 0) begin
                ram_mem[bus.ram_addr[11:0]] = bus.ram_store[7:0];
                if (bus.ram_width != BYTE) ram_mem[bus.ram_addr[11:0] + 12'd1] = bus.ram_store[15:8];
                if (bus.ram_width == WORD) begin
                    ram_mem[bus.ram_addr[11:0] + 12'd2] = bus.ram_store[23:16];
                    ram_mem[bus.ram_addr[11:0] + 12'd3] = bus.ram_store[31:24];
                end
            end
        end else rs <= RAM_FREE;
    end

    // ---------------- reference model (word array, arithmetic extraction)
    logic [31:0] ref_mem [0:1023];
    bit          ref_last_d = 1'b1;

    function automatic bit legal(bit is_d, logic [31:0] a, logic [1:0] w);
        if (!is_d) return a[1:0] == 2'b00;
        case (w)
            2'd0:    return 1'b1;
            2'd1:    return !a[0];
            2'd2:    return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    task automatic ref_exec(input bit is_d, input bit wen, input logic [31:0] a, input logic [1:0] w,
                            input bit uns, input logic [31:0] wd,
                            output logic [31:0] rd, output bit er);
        int          sh;
        logic [31:0] m, v;
        sh = 8 * int'(a[1:0]);
        m  = (w == 2'd0) ? 32'hFF : (w == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        rd = 32'h0;
        er = !legal(is_d, a, w);
        if (er) return;
        if (!is_d) rd = ref_mem[a[11:2]];
        else if (wen) ref_mem[a[11:2]] = (ref_mem[a[11:2]] & ~(m << sh)) | ((wd & m) << sh);
        else begin
            v  = ref_mem[a[11:2]] >> sh;
            rd = v & m;
            if (!uns && w == 2'd0 && v[7])  rd = rd | 32'hFFFF_FF00;
            if (!uns && w == 2'd1 && v[15]) rd = rd | 32'hFFFF_0000;
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] wv);
        ref_mem[a[11:2]] = wv;
        for (int b = 0; b < 4; b++) ram_mem[{a[11:2], 2'(b)}] = wv[8*b +: 8];
    endtask

    // ---------------- checking
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [31:0] f_rd, d_rd, cap_addr;
    logic        f_er, d_er, cap_wen;
    logic [1:0]  cap_w;
    int          f_lat, d_lat, en_cyc;

    // Raise the selected requests one idle cycle later, then watch until each completes.
    task automatic run(input bit fe, input bit de);
        bit fdn, ddn;
        @(posedge ram_clk); #1;
        f_lat = 0; d_lat = 0; en_cyc = 0;
        fdn = !fe; ddn = !de;
        bus.i_req = fe;
        bus.d_req = de;
        for (int c = 1; c <= 40 && !(fdn && ddn); c++) begin
            @(posedge ram_clk); #1;
            if (bus.ram_ren | bus.ram_wen) begin
                en_cyc++;
                cap_addr = bus.ram_addr; cap_w = bus.ram_width; cap_wen = bus.ram_wen;
                chk("one_enable", 32'(bus.ram_ren & bus.ram_wen), 0);
            end
            if (bus.i_rdy | bus.d_rdy) chk("idle_gap", 32'(bus.ram_ren | bus.ram_wen), 0);
            if (bus.i_rdy) begin
                chk("i_rdy_expected", 32'(fdn), 0);
                if (!fdn) begin f_lat = c; f_rd = bus.i_rdata; f_er = bus.i_err; fdn = 1; bus.i_req = 1'b0; end
            end
            if (bus.d_rdy) begin
                chk("d_rdy_expected", 32'(ddn), 0);
                if (!ddn) begin d_lat = c; d_rd = bus.d_rdata; d_er = bus.d_err; ddn = 1; bus.d_req = 1'b0; end
            end
        end
        if (!fdn) begin chk("i_rdy_bound", 32'(fdn), 1); bus.i_req = 1'b0; end
        if (!ddn) begin chk("d_rdy_bound", 32'(ddn), 1); bus.d_req = 1'b0; end
    endtask

    typedef struct {
        bit          is_d;
        bit          wen;
        logic [31:0] addr;
        logic [1:0]  w;
        bit          uns;
        logic [31:0] wd;
        int          mode;
        logic [31:0] exp_rd;
        bit          exp_er;
        int          exp_lat;
        int          exp_en;
    } vec_t;

    function automatic vec_t mk(bit is_d, bit wen, logic [31:0] addr, logic [1:0] w, bit uns,
                                logic [31:0] wd, int mode, logic [31:0] rd, bit er, int lat, int en);
        vec_t v;
        v.is_d = is_d; v.wen = wen; v.addr = addr; v.w = w; v.uns = uns; v.wd = wd;
        v.mode = mode; v.exp_rd = rd; v.exp_er = er; v.exp_lat = lat; v.exp_en = en;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        logic [31:0] fa, da, dwd, e1, e2;
        logic [1:0]  dw;
        bit          dwen, duns, r1, r2, first_d;
        int          kind, l1;

        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_wen = 0; bus.d_addr = 0; bus.d_width = WORD;
        bus.d_unsigned = 0; bus.d_wdata = 0;
        for (int i = 0; i < 1024; i++) poke(32'(i * 4), 32'h0);
        poke(32'h100, 32'hDEADBEEF);
        poke(32'h200, 32'h80FF7F01);

        // ---- reset values
        repeat (2) @(posedge ram_clk);
        #1;
        chk("rst_en",    32'({bus.ram_ren, bus.ram_wen}), 0);
        chk("rst_addr",  bus.ram_addr, 0);
        chk("rst_store", bus.ram_store, 0);
        chk("rst_width", 32'(bus.ram_width), 0);
        chk("rst_flags", 32'({bus.i_rdy, bus.i_err, bus.d_rdy, bus.d_err}), 0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        nrst = 1'b1;

        // ---- simultaneous requests from reset: fetch first, data second
        bus.i_addr = 32'h100;
        bus.d_wen = 0; bus.d_addr = 32'h200; bus.d_width = WORD; bus.d_unsigned = 0;
        run(1, 1);
        chk("pair_i_lat", f_lat, 3);
        chk("pair_i_data", f_rd, 32'hDEADBEEF);
        chk("pair_d_lat", d_lat, 6);
        chk("pair_d_data", d_rd, 32'h80FF7F01);
        ref_last_d = 1;

        // ---- directed vectors
        tv.push_back(mk(0, 0, 32'h100, 2, 0, 0, 0, 32'hDEADBEEF, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h202, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h202, 0, 1, 0, 0, 32'h000000FF, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h202, 1, 0, 0, 0, 32'hFFFF80FF, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h201, 1, 0, 0, 0, 32'h0,        1, 2, 0));
        tv.push_back(mk(1, 0, 32'h203, 0, 0, 0, 0, 32'hFFFFFF80, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h201, 0, 0, 0, 0, 32'h0000007F, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h200, 0, 1, 0, 0, 32'h00000001, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h200, 1, 0, 0, 0, 32'h00007F01, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h200, 2, 0, 0, 0, 32'h80FF7F01, 0, 3, 2));
        tv.push_back(mk(0, 0, 32'h102, 2, 0, 0, 0, 32'h0,        1, 2, 0));
        tv.push_back(mk(1, 0, 32'h200, 3, 0, 0, 0, 32'h0,        1, 2, 0));
        tv.push_back(mk(1, 0, 32'h202, 2, 0, 0, 0, 32'h0,        1, 2, 0));
        tv.push_back(mk(1, 1, 32'h300, 2, 0, 32'h12345678, 0, 32'h0, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h300, 2, 0, 0, 0, 32'h12345678, 0, 3, 2));
        tv.push_back(mk(1, 1, 32'h301, 0, 0, 32'hCDEF00AB, 0, 32'h0, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h300, 2, 0, 0, 0, 32'h1234AB78, 0, 3, 2));
        tv.push_back(mk(1, 1, 32'h302, 1, 0, 32'h0000BEEF, 0, 32'h0, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h300, 2, 0, 0, 0, 32'hBEEFAB78, 0, 3, 2));
        tv.push_back(mk(1, 0, 32'h200, 2, 0, 0, 1, 32'h0,        1, 3, 2));
        tv.push_back(mk(0, 0, 32'h100, 2, 0, 0, 1, 32'h0,        1, 3, 2));
        tv.push_back(mk(1, 0, 32'h200, 2, 0, 0, 2, 32'h0,        1, TO + 1, TO));
        tv.push_back(mk(1, 0, 32'h200, 0, 1, 0, 0, 32'h00000001, 0, 3, 2));

        foreach (tv[k]) begin
            resp_mode = tv[k].mode;
            if (tv[k].is_d) begin
                bus.d_wen = tv[k].wen; bus.d_addr = tv[k].addr; bus.d_width = mem_width_t'(tv[k].w);
                bus.d_unsigned = tv[k].uns; bus.d_wdata = tv[k].wd;
            end else bus.i_addr = tv[k].addr;
            run(!tv[k].is_d, tv[k].is_d);
            chk($sformatf("v%0d_rdata", k), tv[k].is_d ? d_rd : f_rd, tv[k].exp_rd);
            chk($sformatf("v%0d_err", k), 32'(tv[k].is_d ? d_er : f_er), 32'(tv[k].exp_er));
            chk($sformatf("v%0d_lat", k), tv[k].is_d ? d_lat : f_lat, tv[k].exp_lat);
            chk($sformatf("v%0d_en_cycles", k), en_cyc, tv[k].exp_en);
            if (tv[k].exp_en > 0) begin
                chk($sformatf("v%0d_ram_addr", k), cap_addr, tv[k].addr);
                chk($sformatf("v%0d_ram_width", k), 32'(cap_w), tv[k].is_d ? 32'(tv[k].w) : 32'd2);
                chk($sformatf("v%0d_ram_wen", k), 32'(cap_wen), 32'(tv[k].wen));
            end
            ref_last_d = tv[k].is_d;
        end
        resp_mode = 0;

        // ---- reset while BUSY
        resp_mode = 2;
        @(posedge ram_clk); #1;
        bus.d_wen = 0; bus.d_addr = 32'h200; bus.d_width = WORD; bus.d_req = 1;
        repeat (3) @(posedge ram_clk);
        #1;
        chk("busy_ren", 32'(bus.ram_ren), 1);
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_en",    32'({bus.ram_ren, bus.ram_wen}), 0);
        chk("async_rst_addr",  bus.ram_addr, 0);
        chk("async_rst_width", 32'(bus.ram_width), 0);
        chk("async_rst_flags", 32'({bus.i_rdy, bus.i_err, bus.d_rdy, bus.d_err}), 0);
        chk("async_rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        bus.d_req = 0;
        resp_mode = 0;
        @(posedge ram_clk); #1;
        nrst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge ram_clk); #1;
            chk("post_rst_quiet", 32'({bus.i_rdy, bus.d_rdy, bus.ram_ren, bus.ram_wen}), 0);
        end
        ref_last_d = 1;

        // ---- randomized traffic vs model
        for (int i = 0; i < 16; i++) poke(32'h400 + 32'(i * 4), $urandom);
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 2);
            fa = 32'h400 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 5) != 0) fa[1:0] = 2'b00;
            da = 32'h400 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) != 0) da[1:0] = 2'b00;
            dw = 2'($urandom_range(0, 3));
            dwen = 1'($urandom_range(0, 1));
            duns = 1'($urandom_range(0, 1));
            dwd = $urandom;
            bus.i_addr = fa;
            bus.d_wen = dwen; bus.d_addr = da; bus.d_width = mem_width_t'(dw);
            bus.d_unsigned = duns; bus.d_wdata = dwd;
            if (kind == 0) begin
                ref_exec(0, 0, fa, 2'd2, 0, 0, e1, r1);
                run(1, 0);
                chk("rnd_i_data", f_rd, e1);
                chk("rnd_i_err", 32'(f_er), 32'(r1));
                chk("rnd_i_lat", f_lat, r1 ? 2 : 3);
                ref_last_d = 0;
            end else if (kind == 1) begin
                ref_exec(1, dwen, da, dw, duns, dwd, e2, r2);
                run(0, 1);
                chk("rnd_d_data", d_rd, e2);
                chk("rnd_d_err", 32'(d_er), 32'(r2));
                chk("rnd_d_lat", d_lat, r2 ? 2 : 3);
                ref_last_d = 1;
            end else begin
                first_d = !ref_last_d;
                if (first_d) begin
                    ref_exec(1, dwen, da, dw, duns, dwd, e2, r2);
                    ref_exec(0, 0, fa, 2'd2, 0, 0, e1, r1);
                    l1 = r2 ? 2 : 3;
                end else begin
                    ref_exec(0, 0, fa, 2'd2, 0, 0, e1, r1);
                    ref_exec(1, dwen, da, dw, duns, dwd, e2, r2);
                    l1 = r1 ? 2 : 3;
                end
                run(1, 1);
                chk("rnd2_i_data", f_rd, e1);
                chk("rnd2_i_err", 32'(f_er), 32'(r1));
                chk("rnd2_d_data", d_rd, e2);
                chk("rnd2_d_err", 32'(d_er), 32'(r2));
                if (first_d) begin
                    chk("rnd2_d_lat", d_lat, l1);
                    chk("rnd2_i_lat", f_lat, l1 + (r1 ? 2 : 3));
                end else begin
                    chk("rnd2_i_lat", f_lat, l1);
                    chk("rnd2_d_lat", d_lat, l1 + (r2 ? 2 : 3));
                end
                ref_last_d = !first_d;
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

CPU-side initiator for the cpu_ram_if protocol: arbitrates the instruction-fetch port and the data port of the rv32ima core onto the single RAM responder, drives the RAM enable/address/width/store lines, and waits for the RAM_DATA state. It also checks alignment, extracts and extends sub-word loads, and bounds every transaction with a timeout. It sits between the core's fetch/LSU stages and the RAM wrapper.

## Interface
- TIMEOUT, 64: BUSY cycles without RAM_DATA before the transaction is aborted with error.
- ram_clk  in  1  clock; one clock domain.
- nrst  in  1  reset; asynchronous, active-low.
- i_req  in  1  fetch request; held with i_addr until i_rdy.
- i_addr  in  32  fetch byte address.
- i_rdy  out  1  one-cycle completion pulse.
- i_rdata  out  32  fetched word; valid while i_rdy.
- i_err  out  1  error flag; valid while i_rdy.
- d_req  in  1  data request; fields held until d_rdy.
- d_wen  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_width  in  2  mem_width_t: 00 byte, 01 half, 10 word.
- d_unsigned  in  1  zero-extend loads when 1.
- d_wdata  in  32  store data, passed through unchanged.
- d_rdy / d_rdata / d_err  out  1/32/1  as for the fetch port.
- ram_ren, ram_wen  out  1 each  RAM enables; at most one high.
- ram_addr  out  32; ram_store  out  32; ram_width  out  2.
- ram_state  in  ram_state_t  RAM_FREE/ADDR/DATA/ERROR from the responder.
- ram_load  in  32  RAM read data, sampled in the RAM_DATA cycle.

## Operation
- FSM states: IDLE, BUSY, FAULT.
- IDLE: all RAM enables low. If any request is pending, grant one:
  - A lone requester wins.
  - On a tie, the port not granted last time wins (round-robin). last_grant resets to "data", so fetch wins the first tie.
- Alignment check at grant:
  - Fetch must have addr[1:0]=0.
  - Half must have addr[0]=0; word must have addr[1:0]=0.
  - Width 11 is illegal.
  - Violation -> FAULT; the RAM is not touched.
- Legal grant -> BUSY. Registered ram_addr, width and store are loaded; ram_ren or ram_wen is set high. Fetch always issues width 10 as a read.
- BUSY: enables and fields are held stable and the timeout counter increments each cycle.
  - ram_state==RAM_DATA: latch ram_load, then go to IDLE with the rdy pulse.
  - ram_state==RAM_ERROR: go to IDLE with rdy and err.
  - Counter reaching TIMEOUT: go to IDLE with rdy and err.
  - Precedence: DATA > ERROR > timeout.
- FAULT: lasts one cycle, then returns to IDLE with rdy and err. rdata is 0.
- Load extraction (loads only):
  - Shift ram_load right by 8*addr[1:0].
  - Byte: sign- or zero-extend bit 7 per d_unsigned. Half: extend bit 15. Word: pass through.
- Stores: rdata=0 on completion.
- Enables are always low in IDLE. This guarantees one idle cycle between RAM transactions so the responder's ready flag clears.
- The rdy pulse and the new IDLE grant decision occur in the same cycle.

## Timing
- Reset value 0 on every output (enables, ram_addr/store/width, rdy, rdata, err). State resets to IDLE, timeout counter to 0.
- Request sampled in IDLE at edge N:
  - Enables high from cycle N+1.
  - rdy pulses exactly one cycle after the cycle in which RAM_DATA is sampled.
  - With a zero-latency responder, RAM_DATA occurs at N+2 and rdy at N+3.
- Next grant decision is made in the rdy cycle; enables go high again one cycle later.
- Misalignment: rdy+err at N+2.
- Reset mid-transaction: outputs clear immediately and the pending transaction is dropped. Requesters re-present after reset.
- A request deasserted before rdy is a protocol violation; behaviour is undefined.

## Structure
- rv32ima_pkg gains:
  - mem_width_t enum (BYTE=2'b00, HALF=2'b01, WORD=2'b10).
  - arb_state_t (IDLE, BUSY, FAULT).
  - TIMEOUT default constant.
- Existing package types reused: word_t, ram_state_t.
- One sub-module: load_align (combinational shift, sign/zero extend by width/offset/unsigned).

## Test plan
- Zero-latency RAM holding 0xDEADBEEF at 0x100; fetch req addr 0x100 -> i_rdata=0xDEADBEEF, i_err=0, i_rdy three cycles after req sampled.
- Both ports request in the same cycle from reset -> fetch granted first, data second. Ram enables drop for one cycle between the two transactions.
- Word at 0x200 = 0x80FF7F01; byte load at 0x202 signed -> 0xFFFFFFFF; unsigned -> 0x000000FF; half load at 0x202 signed -> 0xFFFF80FF.
- Half load at 0x201 -> d_rdy+d_err, d_rdata=0, ram_ren never asserted.
- Responder held in RAM_ADDR forever with TIMEOUT=8 -> d_rdy+d_err after 8 BUSY cycles, then IDLE.
- nrst pulsed low while BUSY -> all outputs 0 asynchronously. After release with no requests pending, IDLE and no rdy.
